// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like slave port between the instruction
// master (M0) and the data master (M1). Request and response paths are
// combinational pass-through; an in-order ID FIFO steers each data_ok back to
// the master whose request was accepted first.
// Optional feature macro: ARB_RR_EN (round-robin tie break instead of fixed
// M1-over-M0 priority).
module sram_like_arbiter #(
    parameter int unsigned OUTSTANDING = 4,
    parameter int unsigned ID_W        = 1
) (
    input  logic        clk,
    input  logic        reset,
    // instruction master
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,
    // data master
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,
    // slave port
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,
    // sticky protocol error
    output logic        err_unexpected_ok
);

    localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [ID_W-1:0] id_t;

    localparam id_t ID_M0 = ID_W'(0);
    localparam id_t ID_M1 = ID_W'(1);

    // tracking state
    id_t              id_fifo_q [OUTSTANDING];
    logic [PTR_W-1:0] wptr_q,  wptr_d;
    logic [PTR_W-1:0] rptr_q,  rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             lock_valid_q, lock_valid_d;
    id_t              lock_id_q,    lock_id_d;
    id_t              rr_last_q,    rr_last_d;
    logic             err_q,        err_d;

    // combinational helpers
    logic full_c;
    id_t  tie_grant_c;
    id_t  grant_c;
    logic sel_m1_c;
    logic gnt_req_c;
    logic push_c;
    logic pop_c;
    id_t  head_c;

    assign full_c = (count_q == CNT_W'(OUTSTANDING));

    // Tie-break choice when both masters request and no lock is held
`ifdef ARB_RR_EN
    assign tie_grant_c = (rr_last_q == ID_M1) ? ID_M0 : ID_M1;
`else
    // Fixed priority: the data master wins. rr_last is still tracked so the
    // two builds carry the same state, but nothing reads it here.
    id_t rr_unused_c;
    assign tie_grant_c = ID_M1;
    assign rr_unused_c = rr_last_q;
`endif

    // Grant selection: a held lock first, then tie-break, then lone requester
    always_comb begin
        grant_c = ID_M0;
        if (lock_valid_q) begin
            grant_c = lock_id_q;
        end else if (m0_req && m1_req) begin
            grant_c = tie_grant_c;
        end else if (m1_req) begin
            grant_c = ID_M1;
        end
    end

    assign sel_m1_c  = (grant_c == ID_M1);
    assign gnt_req_c = sel_m1_c ? m1_req : m0_req;

    // Request path: mux the granted master onto the slave, zero when idle
    always_comb begin
        s_req   = gnt_req_c & ~full_c;
        s_wr    = 1'b0;
        s_size  = 2'b00;
        s_wstrb = 4'b0000;
        s_addr  = 32'h0;
        s_wdata = 32'h0;
        if (gnt_req_c) begin
            if (sel_m1_c) begin
                s_wr    = m1_wr;
                s_size  = m1_size;
                s_wstrb = m1_wstrb;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
            end else begin
                s_wr    = m0_wr;
                s_size  = m0_size;
                s_wstrb = m0_wstrb;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
            end
        end
    end

    assign push_c     = s_req & s_addr_ok;
    assign m0_addr_ok = push_c & ~sel_m1_c;
    assign m1_addr_ok = push_c &  sel_m1_c;

    // Response path: route data_ok/rdata to the master at the FIFO head
    assign pop_c      = s_data_ok & (count_q != CNT_W'(0));
    assign head_c     = id_fifo_q[rptr_q];
    assign m0_data_ok = pop_c & (head_c == ID_M0);
    assign m1_data_ok = pop_c & (head_c == ID_M1);
    assign m0_rdata   = m0_data_ok ? s_rdata : 32'h0;
    assign m1_rdata   = m1_data_ok ? s_rdata : 32'h0;

    assign err_unexpected_ok = err_q;

    // Next-state for pointers, occupancy, lock, round-robin history and error
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        rr_last_d    = rr_last_q;
        err_d        = err_q;

        if (push_c) begin
            wptr_d    = wptr_q + PTR_W'(1);
            rr_last_d = grant_c;
        end
        if (pop_c) begin
            rptr_d = rptr_q + PTR_W'(1);
        end

        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Hold the port for a master whose request is waiting on addr_ok
        if (push_c) begin
            lock_valid_d = 1'b0;
        end else if (s_req) begin
            lock_valid_d = 1'b1;
            lock_id_d    = grant_c;
        end

        if (s_data_ok && (count_q == CNT_W'(0))) begin
            err_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_id_q    <= ID_M0;
            rr_last_q    <= ID_M0;
            err_q        <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            rr_last_q    <= rr_last_d;
            err_q        <= err_d;
        end
    end

    // ID FIFO storage: record the master of each accepted request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(OUTSTANDING); i++) begin
                id_fifo_q[i] <= ID_M0;
            end
        end else if (push_c) begin
            id_fifo_q[wptr_q] <= grant_c;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (default fixed-priority build).
// Inputs change 1 time unit after the rising edge; outputs are checked 3 units
// later, well before the next edge.
module tb_sram_like_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        err_unexpected_ok;

    int checks = 0;
    int errors = 0;

    sram_like_arbiter #(.OUTSTANDING(4), .ID_W(1)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
        .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
        .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .err_unexpected_ok(err_unexpected_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        m0_req = 1'b0; m0_wr = 1'b0; m0_size = 2'd0; m0_wstrb = 4'h0;
        m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_size = 2'd0; m1_wstrb = 4'h0;
        m1_addr = 32'h0; m1_wdata = 32'h0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #3;
        check("rst_s_req",   32'(s_req), 32'd0);
        check("rst_s_addr",  s_addr, 32'h0);
        check("rst_m0_aok",  32'(m0_addr_ok), 32'd0);
        check("rst_m1_dok",  32'(m1_data_ok), 32'd0);
        check("rst_m0_rd",   m0_rdata, 32'h0);
        check("rst_err",     32'(err_unexpected_ok), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // single requester
        m0_req = 1'b1; m0_addr = 32'hBFC0_0000; s_addr_ok = 1'b1;
        settle();
        check("t1_m0_aok",   32'(m0_addr_ok), 32'd1);
        check("t1_m1_aok",   32'(m1_addr_ok), 32'd0);
        check("t1_s_addr",   s_addr, 32'hBFC0_0000);
        tick();
        idle(); s_data_ok = 1'b1; s_rdata = 32'h3C08_BFAF;
        settle();
        check("t1_m0_dok",   32'(m0_data_ok), 32'd1);
        check("t1_m0_rd",    m0_rdata, 32'h3C08_BFAF);
        check("t1_m1_dok",   32'(m1_data_ok), 32'd0);
        check("t1_m1_rd",    m1_rdata, 32'h0);
        tick();
        idle();

        // collision: data master wins, instruction master next
        m0_req = 1'b1; m0_addr = 32'h100; m1_req = 1'b1; m1_addr = 32'h200; s_addr_ok = 1'b1;
        settle();
        check("t2_m1_aok",   32'(m1_addr_ok), 32'd1);
        check("t2_m0_aok0",  32'(m0_addr_ok), 32'd0);
        check("t2_s_addr1",  s_addr, 32'h200);
        tick();
        m1_req = 1'b0; m1_addr = 32'h0;
        settle();
        check("t2_m0_aok",   32'(m0_addr_ok), 32'd1);
        check("t2_s_addr0",  s_addr, 32'h100);
        tick();
        idle(); s_data_ok = 1'b1; s_rdata = 32'hA;
        settle();
        check("t2_r1_m1",    32'(m1_data_ok), 32'd1);
        check("t2_r1_m0",    32'(m0_data_ok), 32'd0);
        tick();
        s_rdata = 32'hB;
        settle();
        check("t2_r2_m0",    32'(m0_data_ok), 32'd1);
        check("t2_r2_rd",    m0_rdata, 32'hB);
        tick();
        idle();

        // lock: M0 waits on addr_ok, M1 must not steal the port
        m0_req = 1'b1; m0_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t3_wait_addr", s_addr, 32'h300);
            tick();
        end
        m1_req = 1'b1; m1_addr = 32'h400;
        settle();
        check("t3_lock_addr", s_addr, 32'h300);
        check("t3_lock_req",  32'(s_req), 32'd1);
        tick();
        s_addr_ok = 1'b1;
        settle();
        check("t3_m0_aok",   32'(m0_addr_ok), 32'd1);
        check("t3_m1_aok0",  32'(m1_addr_ok), 32'd0);
        check("t3_acc_addr", s_addr, 32'h300);
        tick();
        m0_req = 1'b0; m0_addr = 32'h0;
        settle();
        check("t3_m1_aok",   32'(m1_addr_ok), 32'd1);
        check("t3_m1_addr",  s_addr, 32'h400);
        tick();
        idle(); s_data_ok = 1'b1; s_rdata = 32'hC;
        settle();
        check("t3_r1_m0",    32'(m0_data_ok), 32'd1);
        tick();
        settle();
        check("t3_r2_m1",    32'(m1_data_ok), 32'd1);
        tick();
        idle();

        // ordering: M1 write, M0 read, M1 read
        m1_req = 1'b1; m1_wr = 1'b1; m1_size = 2'd2; m1_wstrb = 4'hF;
        m1_addr = 32'h10; m1_wdata = 32'h55; s_addr_ok = 1'b1;
        settle();
        check("t4_s_wr",     32'(s_wr), 32'd1);
        check("t4_s_wdata",  s_wdata, 32'h55);
        check("t4_s_wstrb",  32'(s_wstrb), 32'hF);
        check("t4_s_size",   32'(s_size), 32'd2);
        check("t4_a1_m1",    32'(m1_addr_ok), 32'd1);
        tick();
        m1_req = 1'b0; m1_wr = 1'b0; m1_wstrb = 4'h0; m1_wdata = 32'h0;
        m0_req = 1'b1; m0_addr = 32'h20;
        settle();
        check("t4_a2_m0",    32'(m0_addr_ok), 32'd1);
        tick();
        m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h30;
        settle();
        check("t4_a3_m1",    32'(m1_addr_ok), 32'd1);
        check("t4_a3_wr",    32'(s_wr), 32'd0);
        tick();
        idle(); s_data_ok = 1'b1; s_rdata = 32'h1;
        settle();
        check("t4_r1_m1",    32'(m1_data_ok), 32'd1);
        check("t4_r1_m0",    32'(m0_data_ok), 32'd0);
        check("t4_r1_rd",    m1_rdata, 32'h1);
        tick();
        s_rdata = 32'h2;
        settle();
        check("t4_r2_m0",    32'(m0_data_ok), 32'd1);
        check("t4_r2_m1",    32'(m1_data_ok), 32'd0);
        check("t4_r2_rd",    m0_rdata, 32'h2);
        tick();
        s_rdata = 32'h3;
        settle();
        check("t4_r3_m1",    32'(m1_data_ok), 32'd1);
        check("t4_r3_rd",    m1_rdata, 32'h3);
        tick();
        idle();

        // full: four accepted, fifth held off until a slot frees
        m0_req = 1'b1; s_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m0_addr = 32'h1000 + 32'(i * 4);
            settle();
            check("t5_fill_aok", 32'(m0_addr_ok), 32'd1);
            tick();
        end
        m0_addr = 32'h1010; s_data_ok = 1'b1; s_rdata = 32'hD0;
        settle();
        check("t5_full_req", 32'(s_req), 32'd0);
        check("t5_full_aok", 32'(m0_addr_ok), 32'd0);
        check("t5_full_dok", 32'(m0_data_ok), 32'd1);
        tick();
        // one slot free: accept the fifth while another response pops
        settle();
        check("t5_pp_aok",   32'(m0_addr_ok), 32'd1);
        check("t5_pp_dok",   32'(m0_data_ok), 32'd1);
        tick();
        s_data_ok = 1'b0; m0_addr = 32'h1014;
        settle();
        check("t5_6th_aok",  32'(m0_addr_ok), 32'd1);
        tick();
        m0_addr = 32'h1018;
        settle();
        check("t5_refull",   32'(s_req), 32'd0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            s_data_ok = 1'b1;
            settle();
            check("t5_drain",  32'(m0_data_ok), 32'd1);
            tick();
        end
        idle();

        // unexpected data_ok with nothing outstanding
        s_data_ok = 1'b1; s_rdata = 32'hEE;
        settle();
        check("t6_m0_dok",   32'(m0_data_ok), 32'd0);
        check("t6_m1_dok",   32'(m1_data_ok), 32'd0);
        check("t6_err_pre",  32'(err_unexpected_ok), 32'd0);
        tick();
        idle();
        settle();
        check("t6_err_set",  32'(err_unexpected_ok), 32'd1);
        tick();
        settle();
        check("t6_err_hold", 32'(err_unexpected_ok), 32'd1);
        tick();

        // asynchronous reset with two requests outstanding
        m1_req = 1'b1; m1_addr = 32'h40; s_addr_ok = 1'b1;
        tick();
        m1_req = 1'b0; m0_req = 1'b1; m0_addr = 32'h44;
        tick();
        idle();
        reset = 1'b1;
        #1;
        check("t7_err_clr",  32'(err_unexpected_ok), 32'd0);
        tick();
        reset = 1'b0;
        s_data_ok = 1'b1; s_rdata = 32'h77;
        settle();
        check("t7_m0_dok",   32'(m0_data_ok), 32'd0);
        check("t7_m1_dok",   32'(m1_data_ok), 32'd0);
        tick();
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
